// File: rtl/sd_arb_pkg.sv
// Shared definitions for the SD command arbiter: state encoding, default widths
// and priority-mode codes.
package sd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  localparam int unsigned CMD_W_DEF = 6;
  localparam int unsigned ARG_W_DEF = 32;

  localparam int unsigned PRIO_RR    = 0;
  localparam int unsigned PRIO_FIXED = 1;

endpackage

// File: rtl/sd_rr_picker.sv
// Combinational winner picker: first requesting channel at or after the start
// index (pointer in round-robin mode, 0 in fixed-priority mode), wrapping.
module sd_rr_picker #(
  parameter int unsigned NCH = 2,
  localparam int unsigned PW = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [PW-1:0]  ptr,
  input  logic           mode,
  output logic [NCH-1:0] win
);

  logic [PW-1:0] start;
  logic [PW-1:0] idx;
  logic          found;

  assign start = mode ? '0 : ptr;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      idx = PW'((32'(start) + k) % NCH);
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sd_cmd_arbiter.sv
// N-channel SD command arbiter: grants one source per command transaction and
// holds its payload until the command manager reports done (or the watchdog fires).
module sd_cmd_arbiter
  import sd_arb_pkg::*;
#(
  parameter int unsigned NCH       = 2,
  parameter int unsigned CMD_W     = CMD_W_DEF,
  parameter int unsigned ARG_W     = ARG_W_DEF,
  parameter int unsigned PRIO_MODE = PRIO_RR,
  parameter int unsigned TIMEOUT   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH-1:0]     req_valid,
  input  logic [NCH*CMD_W-1:0] req_cmd,
  input  logic [NCH*ARG_W-1:0] req_arg,
  input  logic [NCH-1:0]     req_sta40,
  input  logic [NCH-1:0]     req_readit,
  input  logic [NCH-1:0]     req_init,
  output logic [NCH-1:0]     req_ready,
  input  logic               done,
  output logic [CMD_W-1:0]   cmd,
  output logic [ARG_W-1:0]   arg,
  output logic               sta,
  output logic               sta40,
  output logic               readit,
  output logic               init,
  output logic [NCH-1:0]     grant,
  output logic               busy,
  output logic [NCH-1:0]     resp_done,
  output logic [NCH-1:0]     resp_err
);

  localparam int unsigned PW = $clog2(NCH);

  arb_state_e       state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic [ARG_W-1:0] arg_q, arg_d;
  logic             sta_q, sta_d, sta40_q, sta40_d;
  logic             readit_q, readit_d, init_q, init_d;
  logic [NCH-1:0]   grant_q, grant_d;
  logic             busy_q, busy_d;
  logic [NCH-1:0]   resp_done_q, resp_done_d, resp_err_q, resp_err_d;

  logic [NCH-1:0]   win;
  logic [CMD_W-1:0] sel_cmd;
  logic [ARG_W-1:0] sel_arg;
  logic             sel_sta40, sel_readit, sel_init;
  logic [PW-1:0]    owner, ptr_nxt;
  logic             timeout_hit;

  sd_rr_picker #(.NCH(NCH)) u_picker (
    .req  (req_valid),
    .ptr  (ptr_q),
    .mode (PRIO_MODE == PRIO_FIXED),
    .win  (win)
  );

  // Payload mux steered by the one-hot winner.
  always_comb begin
    sel_cmd = '0;
    sel_arg = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      sel_cmd = sel_cmd | (req_cmd[i*CMD_W +: CMD_W] & {CMD_W{win[i]}});
      sel_arg = sel_arg | (req_arg[i*ARG_W +: ARG_W] & {ARG_W{win[i]}});
    end
  end

  assign sel_sta40  = |(req_sta40  & win);
  assign sel_readit = |(req_readit & win);
  assign sel_init   = |(req_init   & win);

  always_comb begin
    owner = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (grant_q[i]) owner = PW'(i);
    end
  end

  assign ptr_nxt = (owner == PW'(NCH - 1)) ? '0 : owner + PW'(1);

  // Watchdog counts WAIT cycles; it restarts from 0 outside WAIT.
  if (TIMEOUT > 0) begin : gen_timer
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer_q, timer_d;

    always_comb begin
      timer_d = '0;
      if (state_q == ST_WAIT) timer_d = timer_q + TW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) timer_q <= '0;
      else     timer_q <= timer_d;
    end

    assign timeout_hit = (state_q == ST_WAIT) && (timer_q == TW'(TIMEOUT - 1));
  end else begin : gen_no_timer
    assign timeout_hit = 1'b0;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cmd_d       = cmd_q;
    arg_d       = arg_q;
    readit_d    = readit_q;
    init_d      = init_q;
    grant_d     = grant_q;
    busy_d      = busy_q;
    sta_d       = 1'b0;
    sta40_d     = 1'b0;
    resp_done_d = '0;
    resp_err_d  = '0;
    req_ready   = '0;

    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          req_ready = win;
          grant_d   = win;
          cmd_d     = sel_cmd;
          arg_d     = sel_arg;
          readit_d  = sel_readit;
          init_d    = sel_init;
          sta_d     = ~sel_sta40;
          sta40_d   = sel_sta40;
          busy_d    = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (done || timeout_hit) begin
          // done takes precedence over a simultaneous watchdog expiry
          if (done) resp_done_d = grant_q;
          else      resp_err_d  = grant_q;
          if (PRIO_MODE == PRIO_RR) ptr_d = ptr_nxt;
          cmd_d    = '0;
          arg_d    = '0;
          readit_d = 1'b0;
          init_d   = 1'b0;
          grant_d  = '0;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cmd_q       <= '0;
      arg_q       <= '0;
      sta_q       <= 1'b0;
      sta40_q     <= 1'b0;
      readit_q    <= 1'b0;
      init_q      <= 1'b0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      resp_done_q <= '0;
      resp_err_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cmd_q       <= cmd_d;
      arg_q       <= arg_d;
      sta_q       <= sta_d;
      sta40_q     <= sta40_d;
      readit_q    <= readit_d;
      init_q      <= init_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      resp_done_q <= resp_done_d;
      resp_err_q  <= resp_err_d;
    end
  end

  assign cmd       = cmd_q;
  assign arg       = arg_q;
  assign sta       = sta_q;
  assign sta40     = sta40_q;
  assign readit    = readit_q;
  assign init      = init_q;
  assign grant     = grant_q;
  assign busy      = busy_q;
  assign resp_done = resp_done_q;
  assign resp_err  = resp_err_q;

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// Bench for sd_cmd_arbiter: a round-robin/TIMEOUT=8 instance and a fixed-priority
// instance share stimulus and are checked every cycle against a transaction model.
module tb_sd_cmd_arbiter;

  localparam int N  = 2;
  localparam int CW = 6;
  localparam int AW = 32;
  localparam int OW = CW + AW + 10;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    req_valid, req_sta40, req_readit, req_init;
  logic [N*CW-1:0] req_cmd;
  logic [N*AW-1:0] req_arg;
  logic            done;

  logic [N-1:0]  rdy_r, rdy_p, grant_r, grant_p, rdone_r, rdone_p, rerr_r, rerr_p;
  logic [CW-1:0] cmd_r, cmd_p;
  logic [AW-1:0] arg_r, arg_p;
  logic sta_r, sta_p, sta40_r, sta40_p, readit_r, readit_p, init_r, init_p, busy_r, busy_p;

  always #5 clk = ~clk;

  sd_cmd_arbiter #(.NCH(N), .CMD_W(CW), .ARG_W(AW), .PRIO_MODE(0), .TIMEOUT(8)) dut_r (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_cmd(req_cmd), .req_arg(req_arg),
    .req_sta40(req_sta40), .req_readit(req_readit), .req_init(req_init),
    .req_ready(rdy_r), .done(done), .cmd(cmd_r), .arg(arg_r), .sta(sta_r),
    .sta40(sta40_r), .readit(readit_r), .init(init_r), .grant(grant_r), .busy(busy_r),
    .resp_done(rdone_r), .resp_err(rerr_r));

  sd_cmd_arbiter #(.NCH(N), .CMD_W(CW), .ARG_W(AW), .PRIO_MODE(1), .TIMEOUT(0)) dut_p (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_cmd(req_cmd), .req_arg(req_arg),
    .req_sta40(req_sta40), .req_readit(req_readit), .req_init(req_init),
    .req_ready(rdy_p), .done(done), .cmd(cmd_p), .arg(arg_p), .sta(sta_p),
    .sta40(sta40_p), .readit(readit_p), .init(init_p), .grant(grant_p), .busy(busy_p),
    .resp_done(rdone_p), .resp_err(rerr_p));

  logic [OW-1:0] outs_r, outs_p;
  assign outs_r = {cmd_r, arg_r, sta_r, sta40_r, readit_r, init_r, grant_r, busy_r, rdone_r, rerr_r};
  assign outs_p = {cmd_p, arg_p, sta_p, sta40_p, readit_p, init_p, grant_p, busy_p, rdone_p, rerr_p};

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: phase 0 idle, 1 issuing, 2 waiting for done.
  int mprio[2] = '{0, 1};
  int mtmo[2]  = '{8, 0};
  int ph[2], owner[2], cnt[2], ptr[2];
  logic [CW-1:0] e_cmd[2];
  logic [AW-1:0] e_arg[2];
  logic e_sta[2], e_sta40[2], e_readit[2], e_init[2], e_busy[2];
  logic [N-1:0] e_grant[2], e_rdone[2], e_rerr[2];

  function automatic int pick(input int m);
    int start = (mprio[m] != 0) ? 0 : ptr[m];
    for (int k = 0; k < N; k++) begin
      if (req_valid[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready(input int m);
    int w = pick(m);
    if (ph[m] != 0 || w < 0) return '0;
    return N'(1 << w);
  endfunction

  function automatic logic [OW-1:0] exp_outs(input int m);
    return {e_cmd[m], e_arg[m], e_sta[m], e_sta40[m], e_readit[m], e_init[m],
            e_grant[m], e_busy[m], e_rdone[m], e_rerr[m]};
  endfunction

  task automatic m_clear(input int m);
    e_cmd[m] = '0; e_arg[m] = '0; e_readit[m] = 0; e_init[m] = 0;
    e_grant[m] = '0; e_busy[m] = 0; ph[m] = 0;
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_clear(m);
      ptr[m] = 0; cnt[m] = 0; owner[m] = 0;
      e_sta[m] = 0; e_sta40[m] = 0; e_rdone[m] = '0; e_rerr[m] = '0;
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      int w;
      e_sta[m] = 0; e_sta40[m] = 0; e_rdone[m] = '0; e_rerr[m] = '0;
      case (ph[m])
        0: begin
          w = pick(m);
          if (w >= 0) begin
            owner[m]    = w;
            e_cmd[m]    = req_cmd[w*CW +: CW];
            e_arg[m]    = req_arg[w*AW +: AW];
            e_readit[m] = req_readit[w];
            e_init[m]   = req_init[w];
            e_sta40[m]  = req_sta40[w];
            e_sta[m]    = !req_sta40[w];
            e_grant[m]  = N'(1 << w);
            e_busy[m]   = 1;
            ph[m]       = 1;
          end
        end
        1: begin ph[m] = 2; cnt[m] = 0; end
        default: begin
          if (done || (mtmo[m] > 0 && cnt[m] == mtmo[m] - 1)) begin
            if (done) e_rdone[m] = N'(1 << owner[m]);
            else      e_rerr[m]  = N'(1 << owner[m]);
            if (mprio[m] == 0) ptr[m] = (owner[m] + 1) % N;
            m_clear(m);
          end else begin
            cnt[m]++;
          end
        end
      endcase
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("rr_ready", rdy_r, exp_ready(0));
      chk("rr_outs",  outs_r, exp_outs(0));
      chk("fp_ready", rdy_p, exp_ready(1));
      chk("fp_outs",  outs_p, exp_outs(1));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Runs one transaction from IDLE with valid held; returns the acceptance vectors.
  task automatic do_txn(input int dly, output logic [N-1:0] rr, output logic [N-1:0] pr);
    @(negedge clk); rr = rdy_r; pr = rdy_p;
    tick();
    tick();
    repeat (dly) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    logic [N-1:0] rr, pr;
    int n;
    rst = 1'b1; done = 1'b0; req_valid = '0; req_sta40 = '0; req_readit = '0;
    req_init = '0; req_cmd = '0; req_arg = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_rr_outs", outs_r, '0);
    chk("reset_fp_outs", outs_p, '0);
    rst = 1'b0;
    chk_en = 1'b1;
    tick();

    // Both channels valid: RR alternates starting at ch0, fixed priority keeps ch0.
    req_valid = 2'b11;
    req_cmd = {6'd12, 6'd41}; req_arg = {32'hCAFE_0001, 32'h1234_5678};
    req_sta40 = 2'b10; req_readit = 2'b01; req_init = 2'b10;
    for (int t = 0; t < 6; t++) begin
      do_txn(int'($urandom_range(0, 5)), rr, pr);
      chk("rr_alternation", rr, (t % 2 == 0) ? 2'b01 : 2'b10);
      chk("fp_always_ch0", pr, 2'b01);
    end
    req_valid = '0;

    // Single ch0 request with sta40.
    req_cmd = '0; req_arg = '0; req_sta40 = 2'b01; req_readit = '0; req_init = '0;
    req_valid = 2'b01;
    @(negedge clk); chk("t1_ready", rdy_r, 2'b01);
    tick();
    @(negedge clk);
    chk("t1_start", {sta_r, sta40_r}, 2'b01);
    chk("t1_grant", grant_r, 2'b01);
    chk("t1_busy", busy_r, 1'b1);
    tick(); req_valid = '0;
    tick(); done = 1'b1;
    tick(); done = 1'b0;
    @(negedge clk);
    chk("t1_resp_done", rdone_r, 2'b01);
    chk("t1_idle", busy_r, 1'b0);

    // done during ISSUE is ignored; second done in WAIT completes.
    req_valid = 2'b10; req_cmd = {6'd5, 6'd0}; req_arg = {32'h0000_00AA, 32'h0};
    req_sta40 = '0;
    tick(); done = 1'b1;
    tick(); done = 1'b0; req_valid = '0;
    @(negedge clk);
    chk("t5_still_busy", busy_r, 1'b1);
    chk("t5_no_done", rdone_r, 2'b00);
    tick(); done = 1'b1;
    tick(); done = 1'b0;
    @(negedge clk);
    chk("t5_resp_done", rdone_r, 2'b10);

    // Watchdog abort on the RR instance.
    req_valid = 2'b01; req_cmd = {6'd0, 6'd9}; req_arg = {32'h0, 32'h0000_0777};
    tick(); req_valid = '0;
    tick();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rerr_r != '0) break;
      @(posedge clk); n++;
    end
    chk("t4_timeout_cycles", n, 8);
    chk("t4_resp_err", rerr_r, 2'b01);
    tick(); done = 1'b1;
    tick(); done = 1'b0;
    req_valid = 2'b11;
    do_txn(1, rr, pr);
    chk("t4_ptr_advanced", rr, 2'b10);
    chk("t4_fp_ch0", pr, 2'b01);
    req_valid = '0;

    // Random traffic checked by the model every cycle.
    repeat (400) begin
      tick();
      req_valid  = N'($urandom);
      req_cmd    = (N*CW)'({$urandom, $urandom});
      req_arg    = {$urandom, $urandom};
      req_sta40  = N'($urandom);
      req_readit = N'($urandom);
      req_init   = N'($urandom);
      done       = ($urandom_range(0, 3) == 0);
    end
    tick(); req_valid = '0; done = 1'b1;
    repeat (12) tick();
    done = 1'b0;

    // Reset in WAIT: everything drops, pointer returns to 0.
    req_valid = 2'b01;
    do_txn(0, rr, pr);
    req_valid = 2'b10; req_cmd = {6'd17, 6'd3}; req_arg = {32'h0000_0200, 32'h5};
    req_sta40 = '0;
    tick(); tick(); req_valid = '0;
    @(negedge clk);
    chk("t6_cmd_held", cmd_r, 6'd17);
    chk("t6_arg_held", arg_r, 32'h0000_0200);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_rr", outs_r, '0);
    chk("t6_async_fp", outs_p, '0);
    tick(); tick();
    req_valid = 2'b11; rst = 1'b0;
    @(negedge clk);
    chk("t6_ptr_reset", rdy_r, 2'b01);
    repeat (4) tick();
    done = 1'b1; tick(); done = 1'b0; req_valid = '0;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
